// File: rtl/turbo_out_sched_if.sv
// Handshake/bus bundle between the turbo output scheduler and its neighbours:
// write-side block notifications in, FIFO read strobes and mux selects out.
interface turbo_out_sched_if;
    logic       blk_done;
    logic       blk_long;
    logic       out_ready;
    logic [1:0] rd_enc;
    logic [1:0] rd_trl;
    logic       sel_bank;
    logic       sel_trl;
    logic       look_now;
    logic       length_out;
    logic [1:0] bank_full;
    logic       overflow;

    modport slave (
        input  blk_done, blk_long, out_ready,
        output rd_enc, rd_trl, sel_bank, sel_trl, look_now, length_out, bank_full, overflow
    );

    modport master (
        output blk_done, blk_long, out_ready,
        input  rd_enc, rd_trl, sel_bank, sel_trl, look_now, length_out, bank_full, overflow
    );
endinterface

// File: rtl/turbo_out_sched.sv
// Read-side scheduler for the turbo encoder ping-pong output FIFO banks.
// Optional feature macro: OUT_SCHED_BACKPRESSURE_EN (out_ready gates every read step).
module turbo_out_sched #(
    parameter int unsigned K_LONG   = 6144,
    parameter int unsigned K_SHORT  = 1056,
    parameter int unsigned TAIL_LEN = 4,
    parameter int unsigned CNT_W    = 14
) (
    input  logic               clk,
    input  logic               rst_n,
    turbo_out_sched_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, ARM, DATA, TAIL} state_t;

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic               r_rd_bank, w_rd_bank_nxt;
    logic               r_wr_bank, w_wr_bank_nxt;
    logic [1:0]         r_bank_full, w_bank_full_nxt;
    logic [1:0]         r_len, w_len_nxt;
    logic               r_overflow, w_overflow_nxt;

    logic               w_go;
    logic               w_enc_strb;
    logic               w_trl_strb;
    logic               w_sel_trl;
    logic               w_release;
    logic [CNT_W-1:0]   w_k_last;

`ifdef OUT_SCHED_BACKPRESSURE_EN
    assign w_go = bus.out_ready;
`else
    // out_ready is folded away so reads run unbroken at one bit per cycle
    assign w_go = bus.out_ready | 1'b1;
`endif

    assign w_k_last = r_len[r_rd_bank] ? CNT_W'(K_LONG - 1) : CNT_W'(K_SHORT - 1);

    // State register and bank bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_rd_bank   <= 1'b0;
            r_wr_bank   <= 1'b0;
            r_bank_full <= 2'b00;
            r_len       <= 2'b00;
            r_overflow  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_rd_bank   <= w_rd_bank_nxt;
            r_wr_bank   <= w_wr_bank_nxt;
            r_bank_full <= w_bank_full_nxt;
            r_len       <= w_len_nxt;
            r_overflow  <= w_overflow_nxt;
        end
    end

    // Next-state, read sequencing and write-side acceptance
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_rd_bank_nxt   = r_rd_bank;
        w_wr_bank_nxt   = r_wr_bank;
        w_bank_full_nxt = r_bank_full;
        w_len_nxt       = r_len;
        w_overflow_nxt  = r_overflow;
        w_enc_strb      = 1'b0;
        w_trl_strb      = 1'b0;
        w_sel_trl       = 1'b0;
        w_release       = 1'b0;

        case (r_state)
            IDLE: begin
                if (r_bank_full[r_rd_bank]) w_state_nxt = ARM;
            end
            ARM: begin
                w_state_nxt = DATA;
                w_cnt_nxt   = '0;
            end
            DATA: begin
                if (w_go) begin
                    w_enc_strb = 1'b1;
                    if (r_cnt == w_k_last) begin
                        w_state_nxt = TAIL;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            TAIL: begin
                w_sel_trl = 1'b1;
                if (w_go) begin
                    w_trl_strb = 1'b1;
                    if (r_cnt == CNT_W'(TAIL_LEN - 1)) begin
                        w_release     = 1'b1;
                        w_rd_bank_nxt = ~r_rd_bank;
                        w_cnt_nxt     = '0;
                        w_state_nxt   = r_bank_full[~r_rd_bank] ? DATA : IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        if (w_release) w_bank_full_nxt[r_rd_bank] = 1'b0;

        // A bank freed on this same edge may be refilled; the set wins
        if (bus.blk_done) begin
            if (!r_bank_full[r_wr_bank] || (w_release && (r_rd_bank == r_wr_bank))) begin
                w_bank_full_nxt[r_wr_bank] = 1'b1;
                w_len_nxt[r_wr_bank]       = bus.blk_long;
                w_wr_bank_nxt              = ~r_wr_bank;
            end else begin
                w_overflow_nxt = 1'b1;
            end
        end
    end

    assign bus.rd_enc     = w_enc_strb ? (r_rd_bank ? 2'b10 : 2'b01) : 2'b00;
    assign bus.rd_trl     = w_trl_strb ? (r_rd_bank ? 2'b10 : 2'b01) : 2'b00;
    assign bus.sel_bank   = r_rd_bank;
    assign bus.sel_trl    = w_sel_trl;
    assign bus.look_now   = w_enc_strb | w_trl_strb;
    assign bus.length_out = ((r_state == DATA) || (r_state == TAIL)) & r_len[r_rd_bank];
    assign bus.bank_full  = r_bank_full;
    assign bus.overflow   = r_overflow;

endmodule

// File: tb/tb_turbo_out_sched.sv
// Scoreboard bench for turbo_out_sched: expected blocks are queued when blk_done
// is driven and retired by a monitor counting the read strobes of each block.
module tb_turbo_out_sched;

    localparam int unsigned K_LONG   = 6144;
    localparam int unsigned K_SHORT  = 1056;
    localparam int unsigned TAIL_LEN = 4;

    typedef struct {
        logic bank;
        logic lng;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    turbo_out_sched_if bus();

    turbo_out_sched dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   blocks_done = 0;
    int   mon_dcnt = 0;
    int   mon_tcnt = 0;
    logic mon_dbank, mon_tbank, mon_len;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic send_blk(input logic lng, input logic bank, input bit will_read);
        @(posedge clk); #1;
        bus.blk_done = 1'b1;
        bus.blk_long = lng;
        if (will_read) sb.push_back('{bank: bank, lng: lng});
        @(posedge clk); #1;
        bus.blk_done = 1'b0;
        bus.blk_long = 1'b0;
    endtask

    task automatic wait_blocks(input int n, input int budget);
        for (int i = 0; i < budget && blocks_done < n; i++) @(posedge clk);
        check("wait_blocks", 32'(blocks_done >= n), 32'd1);
    endtask

    task automatic do_reset();
        #1 rst_n = 1'b0;
        sb.delete();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Counts tail strobes on bank 0 until the n-th one; returns at posedge+1 of that cycle
    task automatic wait_tail0(input int n, output int seen);
        seen = 0;
        for (int i = 0; i < 8000 && seen < n; i++) begin
            @(posedge clk); #1;
            if (bus.rd_trl[0]) seen++;
        end
    endtask

    // Monitor: per-cycle strobe sanity plus per-block retirement against the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or negedge rst_n);
            if (!rst_n) begin
                mon_dcnt = 0;
                mon_tcnt = 0;
            end else begin
                check("strb_1hot", 32'($countones({bus.rd_enc, bus.rd_trl}) <= 1), 32'd1);
                check("look_now", 32'(bus.look_now), 32'(|{bus.rd_enc, bus.rd_trl}));
                if (bus.look_now)
                    check("sel", 32'({bus.sel_trl, bus.sel_bank}),
                          32'({|bus.rd_trl, bus.rd_enc[1] | bus.rd_trl[1]}));
                if (|bus.rd_enc) begin
                    if (mon_dcnt == 0) begin
                        mon_dbank = bus.rd_enc[1];
                        mon_len   = bus.length_out;
                    end
                    mon_dcnt++;
                end
                if (|bus.rd_trl) begin
                    mon_tbank = bus.rd_trl[1];
                    mon_tcnt++;
                    if (mon_tcnt == TAIL_LEN) begin
                        if (sb.size() == 0) begin
                            check("sb_underflow", 32'd1, 32'd0);
                        end else begin
                            e = sb.pop_front();
                            check("blk_k", 32'(mon_dcnt), e.lng ? K_LONG : K_SHORT);
                            check("blk_bank", 32'({mon_dbank, mon_tbank}), 32'({e.bank, e.bank}));
                            check("blk_len", 32'(mon_len), 32'(e.lng));
                        end
                        blocks_done++;
                        mon_dcnt = 0;
                        mon_tcnt = 0;
                    end
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int b;
        int n;
        logic seen;

        rst_n         = 1'b0;
        bus.blk_done  = 1'b0;
        bus.blk_long  = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state and quiet idle
        #12;
        check("rst_outputs", 32'({bus.rd_enc, bus.rd_trl, bus.sel_bank, bus.sel_trl, bus.look_now,
                                  bus.length_out, bus.bank_full, bus.overflow}), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        seen = 1'b0;
        repeat (100) begin
            @(negedge clk);
            seen = seen | bus.look_now;
        end
        check("idle_quiet", 32'(seen), 32'd0);

        // Single short block, with first-strobe latency
        b = blocks_done;
        send_blk(1'b0, 1'b0, 1'b1);
        @(negedge clk) check("lat_idle", 32'({bus.bank_full, bus.rd_enc}), 32'({2'b01, 2'b00}));
        @(negedge clk) check("lat_arm", 32'(bus.rd_enc), 32'd0);
        @(negedge clk) check("lat_data", 32'(bus.rd_enc), 32'b01);
        wait_blocks(b + 1, 2000);
        repeat (3) @(negedge clk);
        check("short_idle", 32'({bus.bank_full, bus.look_now}), 32'd0);

        // Back-to-back long then short, no bubble between banks
        do_reset();
        b = blocks_done;
        send_blk(1'b1, 1'b0, 1'b1);
        repeat (50) @(posedge clk);
        send_blk(1'b0, 1'b1, 1'b1);
        wait_blocks(b + 1, 7000);
        @(negedge clk) check("no_bubble", 32'(bus.rd_enc), 32'b10);
        wait_blocks(b + 2, 2000);

        // Overflow: third block is dropped, wr_bank holds
        do_reset();
        b = blocks_done;
        send_blk(1'b0, 1'b0, 1'b1);
        send_blk(1'b0, 1'b1, 1'b1);
        send_blk(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("ovf_set", 32'(bus.overflow), 32'd1);
        check("ovf_full", 32'(bus.bank_full), 32'b11);
        wait_blocks(b + 2, 4000);
        repeat (20) @(negedge clk);
        check("ovf_drained", 32'({bus.look_now, bus.bank_full}), 32'd0);
        check("ovf_sticky", 32'(bus.overflow), 32'd1);
        send_blk(1'b0, 1'b0, 1'b1);
        wait_blocks(b + 3, 2000);
        do_reset();
        @(negedge clk) check("ovf_rst", 32'(bus.overflow), 32'd0);

        // Refill of bank 0 on its own release edge
        b = blocks_done;
        send_blk(1'b0, 1'b0, 1'b1);
        repeat (20) @(posedge clk);
        send_blk(1'b0, 1'b1, 1'b1);
        wait_tail0(TAIL_LEN, n);
        check("simul_tail_seen", 32'(n), TAIL_LEN);
        bus.blk_done = 1'b1;
        bus.blk_long = 1'b1;
        sb.push_back('{bank: 1'b0, lng: 1'b1});
        @(posedge clk); #1;
        bus.blk_done = 1'b0;
        bus.blk_long = 1'b0;
        #1;
        check("simul_full", 32'(bus.bank_full), 32'b11);
        check("simul_ovf", 32'(bus.overflow), 32'd0);
        check("simul_next", 32'(bus.rd_enc), 32'b10);
        wait_blocks(b + 3, 9000);

`ifdef OUT_SCHED_BACKPRESSURE_EN
        // Ten stalled cycles mid-DATA; block length must still be exact
        do_reset();
        b = blocks_done;
        send_blk(1'b0, 1'b0, 1'b1);
        repeat (100) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (10) begin
            #1 check("stall_quiet", 32'({bus.rd_enc, bus.rd_trl, bus.look_now}), 32'd0);
            @(posedge clk);
        end
        #1 bus.out_ready = 1'b1;
        #1 check("stall_resume", 32'(bus.rd_enc), 32'b01);
        wait_blocks(b + 1, 2000);
`endif

        // Reset in the middle of the tail drops strobes at once
        do_reset();
        send_blk(1'b0, 1'b0, 1'b1);
        wait_tail0(2, n);
        check("mid_tail_seen", 32'(n), 32'd2);
        rst_n = 1'b0;
        #1;
        check("rst_mid_tail", 32'({bus.rd_enc, bus.rd_trl, bus.look_now, bus.sel_trl, bus.bank_full}), 32'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("post_rst_quiet", 32'({bus.look_now, bus.bank_full, bus.overflow}), 32'd0);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
